move_controller: RTL and testbench

- Upstream feeder for checker_board. Converts debounced button pulses into cursor movement and move placement on a 3x3 tic-tac-toe board.
- Owns the board register `mem` and pulses `confirm` once per accepted move.
- Waits for checker_board's verdict, then alternates turns or ends the game.

---
 rtl/move_controller.sv | 185 ++++++++++++++++++
 tb/tb_move_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/move_controller.sv
// move_controller
// ---------------------------------------------------------------------------
// Turns debounced button pulses into cursor movement and mark placement on a
// 3x3 tic-tac-toe board. It owns the board image, pulses confirm once per
// accepted move, waits for the checker's verdict, then alternates turns or
// ends the game.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   btn_up       pulse: cursor row -1 (wraps)
//   btn_down     pulse: cursor row +1 (wraps)
//   btn_left     pulse: cursor col -1 (wraps)
//   btn_right    pulse: cursor col +1 (wraps)
//   btn_select   pulse: place mark at cursor, or start a new game when over
//   game_over    win/draw flag from the checker, sampled at the end of CHECK
//   mem          board image, cell k at mem[2k+1:2k] (00 empty, 01 X, 10 O)
//   confirm      one-cycle pulse while the freshly updated board is presented
//   cursor       cell index 0..8, row-major, 0 = top-left
//   turn         player to move, 0 = X, 1 = O
//   move_count   accepted moves this game, 0..9
//   error        one-cycle pulse after selecting an occupied cell
//   playing      high while buttons are being accepted
// ---------------------------------------------------------------------------
module move_controller #(
   parameter int CHECK_WAIT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_select,
   input  logic        game_over,
   output logic [31:0] mem,
   output logic        confirm,
   output logic [3:0]  cursor,
   output logic        turn,
   output logic [3:0]  move_count,
   output logic        error,
   output logic        playing
);

   typedef enum logic [1:0] {
      PLAY   = 2'd0,
      COMMIT = 2'd1,
      CHECK  = 2'd2,
      OVER   = 2'd3
   } state_t;

   localparam logic [3:0] WAIT_LIMIT = 4'(CHECK_WAIT);

   state_t      state_q, state_d;
   logic [31:0] mem_q, mem_d;
   logic [3:0]  cursor_q, cursor_d;
   logic        turn_q, turn_d;
   logic [3:0]  move_count_q, move_count_d;
   logic [3:0]  wait_q, wait_d;
   logic        confirm_q, confirm_d;
   logic        error_q, error_d;
   logic        playing_q, playing_d;

   logic [4:0]  cell_lsb;
   logic [1:0]  cell_val;
   logic [1:0]  cur_col;

   // Bit offset of the cell under the cursor and its current contents.
   assign cell_lsb = {cursor_q, 1'b0};
   assign cell_val = mem_q[cell_lsb +: 2];

   // Column of the cursor, needed for horizontal wrap.
   always_comb begin
      cur_col = 2'd0;
      case (cursor_q)
         4'd1, 4'd4, 4'd7: cur_col = 2'd1;
         4'd2, 4'd5, 4'd8: cur_col = 2'd2;
         default:          cur_col = 2'd0;
      endcase
   end

   // Next-state logic. Outputs are registered, so confirm/error/playing are
   // computed here for the state being entered.
   always_comb begin
      state_d      = state_q;
      mem_d        = mem_q;
      cursor_d     = cursor_q;
      turn_d       = turn_q;
      move_count_d = move_count_q;
      wait_d       = wait_q;
      confirm_d    = 1'b0;
      error_d      = 1'b0;

      case (state_q)
         PLAY: begin
            if (btn_select) begin
               if (cell_val != 2'b00) begin
                  error_d = 1'b1;
               end else begin
                  mem_d[cell_lsb +: 2] = turn_q ? 2'b10 : 2'b01;
                  confirm_d            = 1'b1;
                  state_d              = COMMIT;
               end
            end else if (btn_up) begin
               cursor_d = (cursor_q >= 4'd3) ? cursor_q - 4'd3 : cursor_q + 4'd6;
            end else if (btn_down) begin
               cursor_d = (cursor_q <= 4'd5) ? cursor_q + 4'd3 : cursor_q - 4'd6;
            end else if (btn_left) begin
               cursor_d = (cur_col == 2'd0) ? cursor_q + 4'd2 : cursor_q - 4'd1;
            end else if (btn_right) begin
               cursor_d = (cur_col == 2'd2) ? cursor_q - 4'd2 : cursor_q + 4'd1;
            end
         end

         COMMIT: begin
            move_count_d = (move_count_q >= 4'd9) ? 4'd9 : move_count_q + 4'd1;
            wait_d       = 4'd0;
            state_d      = CHECK;
         end

         // The counter runs 0..CHECK_WAIT so the checker gets CHECK_WAIT full
         // cycles of settling before its verdict is used.
         CHECK: begin
            if (wait_q == WAIT_LIMIT) begin
               if (game_over || move_count_q == 4'd9) begin
                  state_d = OVER;
               end else begin
                  turn_d  = ~turn_q;
                  state_d = PLAY;
               end
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end

         OVER: begin
            if (btn_select) begin
               mem_d        = 32'd0;
               move_count_d = 4'd0;
               turn_d       = 1'b0;
               cursor_d     = 4'd4;
               state_d      = PLAY;
            end
         end

         default: state_d = PLAY;
      endcase

      playing_d = (state_d == PLAY);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= PLAY;
         mem_q        <= 32'd0;
         cursor_q     <= 4'd4;
         turn_q       <= 1'b0;
         move_count_q <= 4'd0;
         wait_q       <= 4'd0;
         confirm_q    <= 1'b0;
         error_q      <= 1'b0;
         playing_q    <= 1'b1;
      end else begin
         state_q      <= state_d;
         mem_q        <= mem_d;
         cursor_q     <= cursor_d;
         turn_q       <= turn_d;
         move_count_q <= move_count_d;
         wait_q       <= wait_d;
         confirm_q    <= confirm_d;
         error_q      <= error_d;
         playing_q    <= playing_d;
      end
   end

   assign mem        = mem_q;
   assign confirm    = confirm_q;
   assign cursor     = cursor_q;
   assign turn       = turn_q;
   assign move_count = move_count_q;
   assign error      = error_q;
   assign playing    = playing_q;

endmodule

// File: tb/tb_move_controller.sv
// tb_move_controller
// ---------------------------------------------------------------------------
// Self-checking bench for move_controller. Each stimulus cycle pushes the
// expected post-edge outputs into a scoreboard queue; the entry is popped and
// compared one time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_move_controller;

   localparam int CW = 2;

   localparam logic [4:0] B_NONE = 5'b00000;
   localparam logic [4:0] B_R    = 5'b00001;
   localparam logic [4:0] B_L    = 5'b00010;
   localparam logic [4:0] B_D    = 5'b00100;
   localparam logic [4:0] B_U    = 5'b01000;
   localparam logic [4:0] B_S    = 5'b10000;

   logic        clk = 1'b0;
   logic        reset;
   logic        btn_up, btn_down, btn_left, btn_right, btn_select;
   logic        game_over;
   logic [31:0] mem;
   logic        confirm;
   logic [3:0]  cursor;
   logic        turn;
   logic [3:0]  move_count;
   logic        error;
   logic        playing;

   typedef struct packed {
      logic [3:0]  cur;
      logic [31:0] mem;
      logic        turn;
      logic [3:0]  cnt;
      logic        play;
      logic        conf;
      logic        err;
   } exp_t;

   typedef struct packed {
      logic [4:0] btn;
      exp_t       e;
   } vec_t;

   exp_t sb[$];
   vec_t cursorTable[17];

   int checks = 0;
   int errors = 0;

   logic [3:0]  eCur;
   logic [31:0] eMem;
   logic        eTurn;
   logic [3:0]  eCnt;
   logic        eOver;

   move_controller #(.CHECK_WAIT(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .btn_select (btn_select),
      .game_over  (game_over),
      .mem        (mem),
      .confirm    (confirm),
      .cursor     (cursor),
      .turn       (turn),
      .move_count (move_count),
      .error      (error),
      .playing    (playing)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Safety net so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   function automatic exp_t mkExp(input logic [3:0] cur, input logic [31:0] m,
                                  input logic t, input logic [3:0] c,
                                  input logic p, input logic cf, input logic er);
      exp_t e;
      e.cur  = cur;
      e.mem  = m;
      e.turn = t;
      e.cnt  = c;
      e.play = p;
      e.conf = cf;
      e.err  = er;
      return e;
   endfunction

   task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Pops the oldest expectation and compares it with the live outputs.
   task automatic checkOutput(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s scoreboard actual=empty required=entry", tag);
      end else begin
         e = sb.pop_front();
         checkField({tag, " cursor"},     32'(cursor),     32'(e.cur));
         checkField({tag, " mem"},        mem,             e.mem);
         checkField({tag, " turn"},       32'(turn),       32'(e.turn));
         checkField({tag, " move_count"}, 32'(move_count), 32'(e.cnt));
         checkField({tag, " playing"},    32'(playing),    32'(e.play));
         checkField({tag, " confirm"},    32'(confirm),    32'(e.conf));
         checkField({tag, " error"},      32'(error),      32'(e.err));
      end
   endtask

   // Drives one cycle of inputs, records the expected result, then checks it.
   task automatic applyStimulus(input logic rst, input logic [4:0] btn, input logic go,
                                input exp_t e, input string tag);
      sb.push_back(e);
      reset = rst;
      {btn_select, btn_up, btn_down, btn_left, btn_right} = btn;
      game_over = go;
      @(posedge clk);
      #1;
      reset = 1'b0;
      {btn_select, btn_up, btn_down, btn_left, btn_right} = B_NONE;
      checkOutput(tag);
   endtask

   task automatic pressDown();
      eCur = 4'((int'(eCur) + 3) % 9);
      applyStimulus(1'b0, B_D, 1'b0, mkExp(eCur, eMem, eTurn, eCnt, 1'b1, 1'b0, 1'b0), "down");
   endtask

   task automatic pressRight();
      eCur = 4'((int'(eCur) / 3) * 3 + ((int'(eCur) % 3) + 1) % 3);
      applyStimulus(1'b0, B_R, 1'b0, mkExp(eCur, eMem, eTurn, eCnt, 1'b1, 1'b0, 1'b0), "right");
   endtask

   task automatic moveTo(input int target);
      for (int i = 0; i < 3 && (int'(eCur) / 3) != (target / 3); i++) pressDown();
      for (int i = 0; i < 3 && (int'(eCur) % 3) != (target % 3); i++) pressRight();
   endtask

   // Full placement: select, COMMIT, CHECK_WAIT+1 CHECK cycles, verdict.
   task automatic placeMark(input logic go);
      eMem = eMem | (32'(eTurn ? 2 : 1) << (2 * int'(eCur)));
      applyStimulus(1'b0, B_S, 1'b0, mkExp(eCur, eMem, eTurn, eCnt, 1'b0, 1'b1, 1'b0), "place");
      eCnt = eCnt + 4'd1;
      for (int i = 0; i < CW + 1; i++)
         applyStimulus(1'b0, B_NONE, go, mkExp(eCur, eMem, eTurn, eCnt, 1'b0, 1'b0, 1'b0), "check");
      eOver = go || (eCnt == 4'd9);
      if (!eOver) eTurn = ~eTurn;
      applyStimulus(1'b0, B_NONE, go, mkExp(eCur, eMem, eTurn, eCnt, !eOver, 1'b0, 1'b0), "verdict");
   endtask

   initial begin
      reset = 1'b1;
      {btn_select, btn_up, btn_down, btn_left, btn_right} = B_NONE;
      game_over = 1'b0;

      // Cursor walk including every wrap and button-priority case.
      cursorTable[0]  = '{B_R,       mkExp(4'd5, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0)};
      cursorTable[1]  = '{B_D,       mkExp(4'd8, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0)};
      cursorTable[2]  = '{B_R,       mkExp(4'd6, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0)};
      cursorTable[3]  = '{B_U,       mkExp(4'd3, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0)};
      cursorTable[4]  = '{B_L,       mkExp(4'd5, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0)};
      cursorTable[5]  = '{B_U,       mkExp(4'd2, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0)};
      cursorTable[6]  = '{B_L,       mkExp(4'd1, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0)};
      cursorTable[7]  = '{B_L,       mkExp(4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0)};
      cursorTable[8]  = '{B_U,       mkExp(4'd6, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0)};
      cursorTable[9]  = '{B_D,       mkExp(4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0)};
      cursorTable[10] = '{B_L,       mkExp(4'd2, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0)};
      cursorTable[11] = '{B_R,       mkExp(4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0)};
      cursorTable[12] = '{B_U | B_D, mkExp(4'd6, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0)};
      cursorTable[13] = '{B_D | B_L, mkExp(4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0)};
      cursorTable[14] = '{B_L | B_R, mkExp(4'd2, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0)};
      cursorTable[15] = '{B_R,       mkExp(4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0)};
      cursorTable[16] = '{B_NONE,    mkExp(4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0)};

      @(posedge clk);
      #1;
      applyStimulus(1'b1, B_NONE, 1'b0, mkExp(4'd4, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0), "reset");

      for (int i = 0; i < 17; i++)
         applyStimulus(1'b0, cursorTable[i].btn, 1'b0, cursorTable[i].e, $sformatf("cursor[%0d]", i));

      // First move at cell 0; select outranks right, stray buttons in
      // COMMIT/CHECK are dropped.
      applyStimulus(1'b0, B_S | B_R, 1'b0, mkExp(4'd0, 32'h1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0), "first select");
      applyStimulus(1'b0, B_R,       1'b0, mkExp(4'd0, 32'h1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0), "commit exit");
      applyStimulus(1'b0, B_U,       1'b0, mkExp(4'd0, 32'h1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0), "check 1");
      applyStimulus(1'b0, B_S,       1'b0, mkExp(4'd0, 32'h1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0), "check 2");
      applyStimulus(1'b0, B_NONE,    1'b0, mkExp(4'd0, 32'h1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0), "back to play");

      // Occupied cell: one error pulse, nothing else changes.
      applyStimulus(1'b0, B_S,    1'b0, mkExp(4'd0, 32'h1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1), "occupied");
      applyStimulus(1'b0, B_NONE, 1'b0, mkExp(4'd0, 32'h1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0), "error clears");

      // Game 1: X 0,1,2 and O 3,4, win flagged after the fifth move.
      eCur = 4'd0; eMem = 32'h1; eTurn = 1'b1; eCnt = 4'd1; eOver = 1'b0;
      moveTo(3); placeMark(1'b0);
      moveTo(1); placeMark(1'b0);
      moveTo(4); placeMark(1'b0);
      moveTo(2); placeMark(1'b1);
      applyStimulus(1'b0, B_R, 1'b0, mkExp(4'd2, 32'h295, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0), "over ignores right");
      applyStimulus(1'b0, B_S, 1'b0, mkExp(4'd4, 32'h0,   1'b0, 4'd0, 1'b1, 1'b0, 1'b0), "new game 1");

      // Game 2: nine moves with no verdict; full board ends the game.
      eCur = 4'd4; eMem = 32'h0; eTurn = 1'b0; eCnt = 4'd0;
      for (int k = 0; k < 9; k++) begin
         moveTo(k);
         placeMark(1'b0);
      end
      applyStimulus(1'b0, B_D, 1'b0, mkExp(4'd8, 32'h19999, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0), "full board over");
      applyStimulus(1'b0, B_S, 1'b0, mkExp(4'd4, 32'h0,     1'b0, 4'd0, 1'b1, 1'b0, 1'b0), "new game 2");

      // Reset landing in the confirm cycle wipes the move with no late pulse.
      applyStimulus(1'b0, B_S,    1'b0, mkExp(4'd4, 32'h100, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0), "select before reset");
      applyStimulus(1'b1, B_NONE, 1'b0, mkExp(4'd4, 32'h0,   1'b0, 4'd0, 1'b1, 1'b0, 1'b0), "reset in commit");
      applyStimulus(1'b0, B_NONE, 1'b0, mkExp(4'd4, 32'h0,   1'b0, 4'd0, 1'b1, 1'b0, 1'b0), "no late confirm");
      applyStimulus(1'b0, B_NONE, 1'b0, mkExp(4'd4, 32'h0,   1'b0, 4'd0, 1'b1, 1'b0, 1'b0), "still idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
